game_scene_ctrl: RTL and testbench

- Top-level game sequencer for the VGA game. It turns the i_next button and the game events (hit, goal) into a game state.
- It latches that state into a displayed scene only at frame boundaries, so the screen never tears mid-frame.
- It drives per-layer enables for the sprite item instances and keeps a frame-based countdown timer.
- Sits between the VGA display timing generator (frame strobe) and the colour mux in Top.

---
 rtl/game_pkg.sv | 17 +
 rtl/next_btn_sync.sv | 70 +++++++
 rtl/game_scene_ctrl.sv | 119 +++++++++++
 tb/tb_game_scene_ctrl.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared types and widths for the VGA game scene controller.
package game_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        INST  = 3'd1,
        GAME  = 3'd2,
        MODET = 3'd3,
        DIE   = 3'd4,
        WIN   = 3'd5,
        END   = 3'd6
    } state_e;

    localparam int LAYER_W = 7;
    localparam int TIME_W  = 7;

endpackage

// File: rtl/next_btn_sync.sv
// Next-button conditioning: 2-flop synchroniser, optional debounce
// (GAME_NEXT_DEBOUNCE_EN) and rising-edge detect producing a 1-cycle next_p.
module next_btn_sync
    import game_pkg::*;
#(
    parameter int DEBOUNCE_CYC = 250000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic next_p
);

    logic sync1_reg, sync2_reg;
    logic level;
    logic level_d_reg;
    logic next_p_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_reg <= 1'b0;
            sync2_reg <= 1'b0;
        end else begin
            sync1_reg <= btn;
            sync2_reg <= sync2_reg == sync2_reg ? sync1_reg : sync1_reg;
        end
    end

`ifdef GAME_NEXT_DEBOUNCE_EN
    localparam int CW = $clog2(DEBOUNCE_CYC + 1);

    logic [CW-1:0] cnt_reg;
    logic          deb_reg;

    // The debounced level follows only after DEBOUNCE_CYC consecutive differing samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
            deb_reg <= 1'b0;
        end else if (sync2_reg == deb_reg) begin
            cnt_reg <= '0;
        end else if (cnt_reg == CW'(DEBOUNCE_CYC - 1)) begin
            cnt_reg <= '0;
            deb_reg <= sync2_reg;
        end else begin
            cnt_reg <= cnt_reg + CW'(1);
        end
    end

    assign level = deb_reg;
`else
    // Parameter kept so both builds share one interface.
    logic unused_cfg;
    assign unused_cfg = (DEBOUNCE_CYC > 0);
    assign level      = sync2_reg;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_d_reg <= 1'b0;
            next_p_reg  <= 1'b0;
        end else begin
            level_d_reg <= level;
            next_p_reg  <= level & ~level_d_reg;
        end
    end

    assign next_p = next_p_reg;

endmodule

// File: rtl/game_scene_ctrl.sv
// Game sequencer: button/events to FSM state, frame-aligned scene latch,
// layer enables and countdown timer. Optional macro: GAME_NEXT_DEBOUNCE_EN.
module game_scene_ctrl
    import game_pkg::*;
#(
    parameter int FPS          = 60,
    parameter int GAME_TIME_S  = 60,
    parameter int INST_FRAMES  = 600,
    parameter int END_FRAMES   = 300,
    parameter int DEBOUNCE_CYC = 250000
) (
    input  logic               i_clk_25,
    input  logic               i_rst_n,
    input  logic               i_next,
    input  logic               i_frame,
    input  logic               i_hit,
    input  logic               i_goal,
    output logic [2:0]         o_state,
    output logic [2:0]         o_scene,
    output logic [LAYER_W-1:0] o_layer_en,
    output logic               o_scene_chg,
    output logic               o_mode,
    output logic [TIME_W-1:0]  o_time_left
);

    localparam int FMAX = (INST_FRAMES > END_FRAMES) ? INST_FRAMES : END_FRAMES;
    localparam int FW   = $clog2(FMAX) + 1;
    localparam int SW   = $clog2(FPS + 1);

    logic next_p;

    next_btn_sync #(
        .DEBOUNCE_CYC(DEBOUNCE_CYC)
    ) u_next_sync (
        .clk    (i_clk_25),
        .rst_n  (i_rst_n),
        .btn    (i_next),
        .next_p (next_p)
    );

    state_e             state_reg, state_next, scene_reg;
    logic [LAYER_W-1:0] layer_en_reg;
    logic               scene_chg_reg;
    logic               mode_reg;
    logic [TIME_W-1:0]  time_reg;
    logic [FW-1:0]      frame_cnt_reg;
    logic [SW-1:0]      sec_cnt_reg;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:     if (next_p) state_next = INST;
            INST:     if (next_p || frame_cnt_reg >= FW'(INST_FRAMES)) state_next = GAME;
            GAME: begin
                if (i_hit)               state_next = DIE;
                else if (i_goal)         state_next = WIN;
                else if (time_reg == '0) state_next = DIE;
                else if (next_p)         state_next = MODET;
            end
            MODET:    if (next_p) state_next = GAME;
            DIE, WIN: if (next_p) state_next = END;
            END:      if (next_p || frame_cnt_reg >= FW'(END_FRAMES)) state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk_25 or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg     <= IDLE;
            scene_reg     <= IDLE;
            layer_en_reg  <= LAYER_W'(1);
            scene_chg_reg <= 1'b0;
            mode_reg      <= 1'b0;
            time_reg      <= TIME_W'(GAME_TIME_S);
            frame_cnt_reg <= '0;
            sec_cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;

            if (state_next != state_reg)
                frame_cnt_reg <= '0;
            else if (i_frame && frame_cnt_reg != {FW{1'b1}})
                frame_cnt_reg <= frame_cnt_reg + FW'(1);

            // A fresh game restarts the clock; resuming from MODET does not.
            if (state_reg == INST && state_next == GAME) begin
                time_reg    <= TIME_W'(GAME_TIME_S);
                sec_cnt_reg <= '0;
            end else if (state_reg == GAME && i_frame) begin
                if (sec_cnt_reg == SW'(FPS - 1)) begin
                    sec_cnt_reg <= '0;
                    if (time_reg != '0)
                        time_reg <= time_reg - TIME_W'(1);
                end else begin
                    sec_cnt_reg <= sec_cnt_reg + SW'(1);
                end
            end

            if (state_reg == GAME && state_next == MODET)
                mode_reg <= ~mode_reg;

            // Scene follows the pre-edge state so a same-cycle transition shows next frame.
            scene_chg_reg <= 1'b0;
            if (i_frame) begin
                scene_reg     <= state_reg;
                layer_en_reg  <= LAYER_W'(1) << state_reg;
                scene_chg_reg <= (scene_reg != state_reg);
            end
        end
    end

    assign o_state     = state_reg;
    assign o_scene     = scene_reg;
    assign o_layer_en  = layer_en_reg;
    assign o_scene_chg = scene_chg_reg;
    assign o_mode      = mode_reg;
    assign o_time_left = time_reg;

endmodule

// File: tb/tb_game_scene_ctrl.sv
// Directed bench for game_scene_ctrl with a frame/second-level reference model.
module tb_game_scene_ctrl;

    localparam int FPS = 4, GT = 2, INSTF = 20, ENDF = 300, DEB = 8;
`ifdef GAME_NEXT_DEBOUNCE_EN
    localparam int LAT = 3 + DEB;
    localparam int HOLD = 20;
`else
    localparam int LAT = 3;
    localparam int HOLD = 3;
`endif

    logic clk = 0, rst_n = 0;
    logic i_next = 0, i_frame = 0, i_hit = 0, i_goal = 0;
    logic [2:0] o_state, o_scene;
    logic [6:0] o_layer_en, o_time_left;
    logic o_scene_chg, o_mode;

    int checks = 0, failures = 0;
    bit chg_seen, chg_after;

    game_scene_ctrl #(
        .FPS(FPS), .GAME_TIME_S(GT), .INST_FRAMES(INSTF),
        .END_FRAMES(ENDF), .DEBOUNCE_CYC(DEB)
    ) dut (
        .i_clk_25(clk), .i_rst_n(rst_n), .i_next(i_next), .i_frame(i_frame),
        .i_hit(i_hit), .i_goal(i_goal), .o_state(o_state), .o_scene(o_scene),
        .o_layer_en(o_layer_en), .o_scene_chg(o_scene_chg), .o_mode(o_mode),
        .o_time_left(o_time_left)
    );

    always #5 clk = ~clk;

    // Reference model: frames spent in GAME give the time left directly.
    int m_state = 0, m_scene = 0, m_mode = 0, m_gf = 0, m_fcnt = 0, ns;
    bit m_chg = 0, m_np = 0, np_use;
    logic [63:0] hist = '0;
`ifdef GAME_NEXT_DEBOUNCE_EN
    bit deb_m = 0, deb_d = 0, all_diff;
`endif

    function automatic int exp_time();
        int t;
        t = GT - m_gf / FPS;
        return (t < 0) ? 0 : t;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_state = 0; m_scene = 0; m_mode = 0; m_gf = 0; m_fcnt = 0;
            m_chg = 0; m_np = 0; hist = '0;
`ifdef GAME_NEXT_DEBOUNCE_EN
            deb_m = 0; deb_d = 0;
`endif
        end else begin
            np_use = m_np;
            hist = {hist[62:0], i_next};
`ifdef GAME_NEXT_DEBOUNCE_EN
            all_diff = 1;
            for (int j = 2; j <= DEB + 1; j++) if (hist[j] == deb_m) all_diff = 0;
            m_np = deb_m & ~deb_d;
            deb_d = deb_m;
            if (all_diff) deb_m = ~deb_m;
`else
            m_np = hist[2] & ~hist[3];
`endif
            ns = m_state;
            case (m_state)
                0: if (np_use) ns = 1;
                1: if (np_use || m_fcnt >= INSTF) ns = 2;
                2: if (i_hit) ns = 4; else if (i_goal) ns = 5;
                   else if (exp_time() == 0) ns = 4; else if (np_use) ns = 3;
                3: if (np_use) ns = 2;
                4, 5: if (np_use) ns = 6;
                6: if (np_use || m_fcnt >= ENDF) ns = 0;
                default: ns = 0;
            endcase
            if (m_state == 2 && ns == 3) m_mode = 1 - m_mode;
            if (m_state == 1 && ns == 2) m_gf = 0;
            else if (m_state == 2 && i_frame) m_gf++;
            if (ns != m_state) m_fcnt = 0; else if (i_frame) m_fcnt++;
            if (i_frame) begin m_chg = (m_state != m_scene); m_scene = m_state; end
            else m_chg = 0;
            m_state = ns;
        end
    end

    always @(negedge clk) begin
        checks++;
        if (o_state !== 3'(m_state) || o_scene !== 3'(m_scene) || o_layer_en !== 7'(1 << m_scene) ||
            o_scene_chg !== m_chg || o_mode !== 1'(m_mode) || o_time_left !== 7'(exp_time())) begin
            failures++;
            $display("FAIL cycle_cmp t=%0t got st=%0d sc=%0d le=%b chg=%b md=%b tl=%0d exp st=%0d sc=%0d chg=%b md=%0d tl=%0d",
                     $time, o_state, o_scene, o_layer_en, o_scene_chg, o_mode, o_time_left,
                     m_state, m_scene, m_chg, m_mode, exp_time());
        end
    end

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic frame(input int n);
        repeat (n) begin
            i_frame = 1; tick(1); i_frame = 0; tick(1);
        end
    endtask

    // Press i_next (held HOLD cycles); optionally raise i_frame for one cycle after cycle fc.
    task automatic press_frame(input int fc);
        i_next = 1;
        for (int c = 1; c <= HOLD + LAT + 4; c++) begin
            tick(1);
            if (c == HOLD) i_next = 0;
            if (c == fc) i_frame = 1;
            if (c == fc + 1) begin i_frame = 0; chg_seen = o_scene_chg; end
            if (c == fc + 2) chg_after = o_scene_chg;
        end
        $display("press done state=%0d scene=%0d", o_state, o_scene);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_state", o_state, 0);
        chk("rst_scene", o_scene, 0);
        chk("rst_layer", o_layer_en, 1);
        chk("rst_chg", o_scene_chg, 0);
        chk("rst_mode", o_mode, 0);
        chk("rst_time", o_time_left, GT);
        rst_n = 1;
        tick(2);

`ifdef GAME_NEXT_DEBOUNCE_EN
        i_next = 1; tick(5); i_next = 0; tick(LAT + 5);
        chk("glitch_ignored", o_state, 0);
        $display("glitch state=%0d", o_state);
`endif
        i_next = 1;
        for (int c = 1; c <= 40; c++) begin
            tick(1);
            if (c == HOLD) i_next = 0;
            if (c == LAT) chk("next_latency_before", o_state, 0);
            if (c == LAT + 1) chk("next_latency_at", o_state, 1);
        end
        chk("single_transition", o_state, 1);
        $display("idle->inst state=%0d", o_state);

        frame(INSTF);
        chk("inst_auto_game", o_state, 2);
        chk("game_time_start", o_time_left, 2);
        frame(3);
        chk("time_3frames", o_time_left, 2);
        frame(1);
        chk("time_4frames", o_time_left, 1);
        frame(4);
        chk("timeout_die", o_state, 4);
        chk("time_zero", o_time_left, 0);
        $display("timeout state=%0d time=%0d", o_state, o_time_left);

        press_frame(0);
        chk("die_to_end", o_state, 6);
        frame(ENDF);
        chk("end_auto_idle", o_state, 0);
        press_frame(0);
        press_frame(0);
        chk("press_game", o_state, 2);
        chk("time_reload", o_time_left, GT);
        i_hit = 1; i_goal = 1; tick(1); i_hit = 0; i_goal = 0;
        chk("hit_over_goal", o_state, 4);
        $display("hit+goal state=%0d", o_state);

        frame(1);
        chk("scene_die", o_scene, 4);
        press_frame(LAT + 5);
        chk("scene_end", o_scene, 6);
        chk("layer_end", o_layer_en, 64);
        chk("chg_pulse", chg_seen, 1);
        chk("chg_clear", chg_after, 0);
        press_frame(LAT);
        chk("same_cycle_state", o_state, 0);
        chk("same_cycle_scene", o_scene, 6);
        chk("same_cycle_nochg", chg_seen, 0);
        i_frame = 1; tick(1); i_frame = 0;
        chk("next_frame_scene", o_scene, 0);
        chk("next_frame_chg", o_scene_chg, 1);
        chk("next_frame_layer", o_layer_en, 1);

        press_frame(0);
        press_frame(0);
        frame(5);
        chk("pre_modet_time", o_time_left, 1);
        press_frame(0);
        chk("modet_state", o_state, 3);
        chk("modet_mode", o_mode, 1);
        i_hit = 1; i_goal = 1; tick(2); i_hit = 0; i_goal = 0;
        chk("modet_ignores_events", o_state, 3);
        frame(10);
        chk("modet_frozen", o_time_left, 1);
        press_frame(0);
        chk("resume_game", o_state, 2);
        frame(2);
        chk("resume_time", o_time_left, 1);
        frame(1);
        chk("resume_expire", o_state, 4);
        $display("modet cycle done state=%0d mode=%0d", o_state, o_mode);

        press_frame(0);
        press_frame(0);
        press_frame(0);
        press_frame(0);
        i_goal = 1; tick(1); i_goal = 0;
        chk("goal_win", o_state, 5);

        tick(1);
        #2 rst_n = 0;
        #1;
        chk("async_rst_state", o_state, 0);
        chk("async_rst_mode", o_mode, 0);
        chk("async_rst_layer", o_layer_en, 1);
        tick(2);
        rst_n = 1;
        tick(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
